// File: rtl/cu_pkg.sv
// ============================================================================
// Module : cu_pkg
// Brief  : Shared state, opcode and mux/ALU encodings for the multicycle CU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } cuState_t;

    localparam int unsigned OP_APUT  = 0;
    localparam int unsigned OP_ADD   = 1;
    localparam int unsigned OP_SUB   = 2;
    localparam int unsigned OP_LOAD  = 3;
    localparam int unsigned OP_STORE = 4;
    localparam int unsigned OP_BEQ   = 5;
    localparam int unsigned OP_JAL   = 6;
    localparam int unsigned OP_RET   = 7;
    localparam int unsigned OP_PUSH  = 8;
    localparam int unsigned OP_POP   = 9;

    localparam logic [1:0] MARY_ALU     = 2'b00;
    localparam logic [1:0] MARY_MEM     = 2'b01;
    localparam logic [1:0] MARY_SHELLEY = 2'b10;
    localparam logic [1:0] MARY_IMM     = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_PASSB = 2'b10;

endpackage

`default_nettype wire

// File: rtl/cu_mem_wait.sv
// ============================================================================
// Module : cu_mem_wait
// Brief  : Memory-wait counter; flags a timeout on the held cycle whose count
//          reaches all-ones while ready is still low.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_mem_wait #(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    input  logic i_ready,
    output logic o_timeout
);

    // r_count holds the number of already-held cycles, so the current cycle
    // is held cycle r_count+1; fire when that reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] c_lastWait = {TIMEOUT_W{1'b1}} - 1'b1;

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || !i_wait || i_ready) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = i_wait && !i_ready && (r_count == c_lastWait);

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module : multicycle_control_unit
// Brief  : FETCH/DECODE/EXEC/MEM/WB sequencer for the accumulator CPU with a
//          memory-ready timeout. Optional stack ops enabled by CU_STACK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W  = 5,
    parameter int ALUOP_W   = 2,
    parameter int TIMEOUT_W = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                flagbit,
    input  logic                CompFlag,
    input  logic                MemReady,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemSrc,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MaryWrite,
    output logic                ShelleyWrite,
    output logic                CompWrite,
    output logic                RAWrite,
    output logic                PCWrite,
    output logic                SPWrite,
    output logic [1:0]          MarySrc,
    output logic                ShelleySrc,
    output logic                RASrc,
    output logic                PCSrc,
    output logic                SPSrc,
    output logic                RegDst,
    output logic                RegData,
    output logic                SrcA,
    output logic                SrcB,
    output logic [ALUOP_W-1:0]  ALUOP,
    output logic                Fault,
    output logic                Busy
);

`ifdef CU_STACK_EN
    localparam int unsigned c_lastOp = OP_POP;
`else
    localparam int unsigned c_lastOp = OP_RET;
`endif

    cuState_t            r_state;
    cuState_t            w_nextState;
    logic [OPCODE_W-1:0] r_opcode;
    logic                r_flag;
    logic                r_fault;
    logic                w_setFault;
    logic                w_wait;
    logic                w_timeout;
    logic                w_opLegal;
    logic                w_decodeFault;
    logic                w_isStore;
    logic                w_isMemToMary;

    assign w_opLegal     = (r_opcode <= OPCODE_W'(c_lastOp));
    assign w_decodeFault = (r_state == S_DECODE) && !w_opLegal;
    assign w_isStore     = (r_opcode == OPCODE_W'(OP_STORE));
    assign w_isMemToMary = (r_opcode == OPCODE_W'(OP_LOAD)) || (r_opcode == OPCODE_W'(OP_POP));

`ifdef CU_STACK_EN
    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM) ||
                    ((r_state == S_EXEC) && (r_opcode == OPCODE_W'(OP_PUSH)));
`else
    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM);
`endif

    cu_mem_wait #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_memWait (
        .clk       (CLK),
        .rst       (Reset),
        .i_wait    (w_wait),
        .i_ready   (MemReady),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
            r_flag   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == S_FETCH) && MemReady) begin
                r_opcode <= OPCODE;
                r_flag   <= flagbit;
            end
            if (w_setFault) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Decode faults show immediately in DECODE; timeout faults after the edge.
    assign Fault = !Reset && (r_fault || w_decodeFault);

    always_comb begin
        w_nextState  = r_state;
        w_setFault   = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemSrc       = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MaryWrite    = 1'b0;
        ShelleyWrite = 1'b0;
        CompWrite    = 1'b0;
        RAWrite      = 1'b0;
        PCWrite      = 1'b0;
        SPWrite      = 1'b0;
        MarySrc      = MARY_ALU;
        ShelleySrc   = 1'b0;
        RASrc        = 1'b0;
        PCSrc        = 1'b0;
        SPSrc        = 1'b0;
        RegDst       = 1'b0;
        RegData      = 1'b0;
        SrcA         = 1'b0;
        SrcB         = 1'b0;
        ALUOP        = ALUOP_W'(ALU_ADD);
        Busy         = 1'b0;

        if (!Reset) begin
            Busy = (r_state != S_FETCH);
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (MemReady) begin
                        IRWrite     = 1'b1;
                        PCWrite     = 1'b1;
                        w_nextState = S_DECODE;
                    end else if (w_timeout) begin
                        w_setFault  = 1'b1;
                        w_nextState = S_HALT;
                    end
                end
                S_DECODE: begin
                    if (!w_opLegal) begin
                        w_setFault  = 1'b1;
                        w_nextState = S_HALT;
                    end else begin
                        w_nextState = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_opcode)
                        OPCODE_W'(OP_APUT): w_nextState = S_WB;
                        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                            ALUOP       = (r_opcode == OPCODE_W'(OP_SUB)) ?
                                          ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
                            SrcB        = 1'b1;
                            CompWrite   = 1'b1;
                            w_nextState = S_WB;
                        end
                        OPCODE_W'(OP_LOAD), OPCODE_W'(OP_STORE): begin
                            ALUOP       = ALUOP_W'(ALU_PASSB);
                            w_nextState = S_MEM;
                        end
                        OPCODE_W'(OP_BEQ): begin
                            PCWrite     = CompFlag;
                            PCSrc       = 1'b1;
                            w_nextState = S_FETCH;
                        end
                        OPCODE_W'(OP_JAL): begin
                            RAWrite     = 1'b1;
                            PCWrite     = 1'b1;
                            PCSrc       = 1'b1;
                            w_nextState = S_FETCH;
                        end
                        OPCODE_W'(OP_RET): begin
                            PCWrite     = 1'b1;
                            PCSrc       = 1'b1;
                            RASrc       = 1'b1;
                            w_nextState = S_FETCH;
                        end
`ifdef CU_STACK_EN
                        OPCODE_W'(OP_PUSH): begin
                            // SP moves only on the cycle the write completes.
                            SPWrite  = MemReady;
                            MemWrite = 1'b1;
                            MemSrc   = 1'b1;
                            if (MemReady) begin
                                w_nextState = S_FETCH;
                            end else if (w_timeout) begin
                                w_setFault  = 1'b1;
                                w_nextState = S_HALT;
                            end
                        end
                        OPCODE_W'(OP_POP): begin
                            SPWrite     = 1'b1;
                            SPSrc       = 1'b1;
                            w_nextState = S_MEM;
                        end
`endif
                        default: w_nextState = S_HALT;
                    endcase
                end
                S_MEM: begin
                    MemSrc   = 1'b1;
                    MemRead  = !w_isStore;
                    MemWrite = w_isStore;
                    if (MemReady) begin
                        w_nextState = w_isStore ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        w_setFault  = 1'b1;
                        w_nextState = S_HALT;
                    end
                end
                S_WB: begin
                    if (r_opcode == OPCODE_W'(OP_APUT)) begin
                        if (r_flag) begin
                            ShelleyWrite = 1'b1;
                            ShelleySrc   = 1'b1;
                        end else begin
                            MaryWrite = 1'b1;
                            MarySrc   = MARY_IMM;
                        end
                    end else begin
                        MaryWrite = 1'b1;
                        MarySrc   = w_isMemToMary ? MARY_MEM : MARY_ALU;
                    end
                    w_nextState = S_FETCH;
                end
                S_HALT: w_nextState = S_HALT;
                default: w_nextState = S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module : tb_multicycle_control_unit
// Brief  : Scoreboard bench for multicycle_control_unit; per-cycle expected
//          output words are queued with the stimulus and compared at negedge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

    localparam logic [31:0] B_MR   = 32'h1 << 0;
    localparam logic [31:0] B_MW   = 32'h1 << 1;
    localparam logic [31:0] B_MS   = 32'h1 << 2;
    localparam logic [31:0] B_IR   = 32'h1 << 3;
    localparam logic [31:0] B_MYW  = 32'h1 << 5;
    localparam logic [31:0] B_SHW  = 32'h1 << 6;
    localparam logic [31:0] B_CW   = 32'h1 << 7;
    localparam logic [31:0] B_RAW  = 32'h1 << 8;
    localparam logic [31:0] B_PCW  = 32'h1 << 9;
    localparam logic [31:0] B_SPW  = 32'h1 << 10;
    localparam logic [31:0] M_MEM  = 32'h1 << 11;
    localparam logic [31:0] M_IMM  = 32'h3 << 11;
    localparam logic [31:0] B_SHS  = 32'h1 << 13;
    localparam logic [31:0] B_RAS  = 32'h1 << 14;
    localparam logic [31:0] B_PCS  = 32'h1 << 15;
    localparam logic [31:0] B_SPS  = 32'h1 << 16;
    localparam logic [31:0] B_SB   = 32'h1 << 20;
    localparam logic [31:0] A_SUB  = 32'h1 << 21;
    localparam logic [31:0] A_PASS = 32'h2 << 21;
    localparam logic [31:0] B_F    = 32'h1 << 23;
    localparam logic [31:0] B_BSY  = 32'h1 << 24;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [4:0] OPCODE;
    logic       flagbit, CompFlag, MemReady;
    logic       MemRead, MemWrite, MemSrc, IRWrite, RegWrite, MaryWrite, ShelleyWrite;
    logic       CompWrite, RAWrite, PCWrite, SPWrite;
    logic [1:0] MarySrc;
    logic       ShelleySrc, RASrc, PCSrc, SPSrc, RegDst, RegData, SrcA, SrcB;
    logic [1:0] ALUOP;
    logic       Fault, Busy;

    multicycle_control_unit #(
        .OPCODE_W  (5),
        .ALUOP_W   (2),
        .TIMEOUT_W (4)
    ) dut (
        .CLK (CLK), .Reset (Reset), .OPCODE (OPCODE), .flagbit (flagbit),
        .CompFlag (CompFlag), .MemReady (MemReady),
        .MemRead (MemRead), .MemWrite (MemWrite), .MemSrc (MemSrc),
        .IRWrite (IRWrite), .RegWrite (RegWrite), .MaryWrite (MaryWrite),
        .ShelleyWrite (ShelleyWrite), .CompWrite (CompWrite), .RAWrite (RAWrite),
        .PCWrite (PCWrite), .SPWrite (SPWrite), .MarySrc (MarySrc),
        .ShelleySrc (ShelleySrc), .RASrc (RASrc), .PCSrc (PCSrc), .SPSrc (SPSrc),
        .RegDst (RegDst), .RegData (RegData), .SrcA (SrcA), .SrcB (SrcB),
        .ALUOP (ALUOP), .Fault (Fault), .Busy (Busy)
    );

    always #5 CLK = ~CLK;

    logic [31:0] w_obs;
    assign w_obs = {7'd0, Busy, Fault, ALUOP, SrcB, SrcA, RegData, RegDst, SPSrc, PCSrc,
                    RASrc, ShelleySrc, MarySrc, SPWrite, PCWrite, RAWrite, CompWrite,
                    ShelleyWrite, MaryWrite, RegWrite, IRWrite, MemSrc, MemWrite, MemRead};

    typedef struct {
        string       tag;
        int          cyc;
        logic [31:0] val;
    } sbItem_t;

    sbItem_t sbq[$];
    int      cyc   = 0;
    int      total = 0;
    int      bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc%0d: got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        while (sbq.size() != 0 && sbq[0].cyc == cyc) begin
            sbItem_t e;
            e = sbq.pop_front();
            chk(e.tag, w_obs, e.val);
        end
    end

    task automatic step(input string tag, input logic [31:0] exp);
        sbq.push_back('{tag, cyc, exp});
        @(posedge CLK);
        #1;
    endtask

    // Fetch with a number of stall cycles; OPCODE is scrambled afterwards to
    // prove it was latched.
    task automatic fetchI(input logic [4:0] op, input logic flg, input int waits);
        MemReady = 1'b0;
        for (int i = 0; i < waits; i++) step("fetchWait", B_MR);
        MemReady = 1'b1;
        OPCODE   = op;
        flagbit  = flg;
        step("fetch", B_MR | B_IR | B_PCW);
        OPCODE   = 5'h1e;
        flagbit  = ~flg;
    endtask

    task automatic loadI(input int waits);
        fetchI(5'd3, 1'b0, 0);
        step("loadDecode", B_BSY);
        step("loadExec", B_BSY | A_PASS);
        MemReady = 1'b0;
        for (int i = 0; i < waits; i++) step("loadMemWait", B_BSY | B_MR | B_MS);
        MemReady = 1'b1;
        step("loadMem", B_BSY | B_MR | B_MS);
        step("loadWb", B_BSY | B_MYW | M_MEM);
    endtask

    task automatic faultReset();
        Reset = 1'b1;
        step("faultReset", 32'h0);
        Reset    = 1'b0;
        MemReady = 1'b1;
    endtask

    initial begin
        Reset = 1'b1; MemReady = 1'b1; OPCODE = 5'd0; flagbit = 1'b0; CompFlag = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) step("reset", 32'h0);
        Reset = 1'b0;

        // APUT to Mary, then to Shelley with a fetch stall
        fetchI(5'd0, 1'b0, 0);
        step("aputDecode", B_BSY);
        step("aputExec", B_BSY);
        step("aputWbMary", B_BSY | B_MYW | M_IMM);
        fetchI(5'd0, 1'b1, 2);
        step("aputDecode", B_BSY);
        step("aputExec", B_BSY);
        step("aputWbShelley", B_BSY | B_SHW | B_SHS);

        // ADD / SUB
        fetchI(5'd1, 1'b0, 0);
        step("addDecode", B_BSY);
        step("addExec", B_BSY | B_CW | B_SB);
        step("addWb", B_BSY | B_MYW);
        fetchI(5'd2, 1'b0, 0);
        step("subDecode", B_BSY);
        step("subExec", B_BSY | B_CW | B_SB | A_SUB);
        step("subWb", B_BSY | B_MYW);

        // LOAD with 3 stalls, then the last stall before timeout
        loadI(3);
        loadI(14);

        // BEQ not taken then taken, JAL, RET
        fetchI(5'd5, 1'b0, 0);
        step("beqDecode", B_BSY);
        CompFlag = 1'b0;
        step("beqNotTaken", B_BSY | B_PCS);
        fetchI(5'd5, 1'b0, 0);
        step("beqDecode", B_BSY);
        CompFlag = 1'b1;
        step("beqTaken", B_BSY | B_PCS | B_PCW);
        CompFlag = 1'b0;
        fetchI(5'd6, 1'b0, 0);
        step("jalDecode", B_BSY);
        step("jalExec", B_BSY | B_RAW | B_PCW | B_PCS);
        fetchI(5'd7, 1'b0, 0);
        step("retDecode", B_BSY);
        step("retExec", B_BSY | B_PCW | B_PCS | B_RAS);

        // reset mid-instruction abandons it
        fetchI(5'd1, 1'b0, 0);
        Reset = 1'b1;
        step("midReset", 32'h0);
        Reset = 1'b0;
        fetchI(5'd4, 1'b0, 0);
        step("storeDecode", B_BSY);
        step("storeExec", B_BSY | A_PASS);
        step("storeMem", B_BSY | B_MW | B_MS);

        // stack opcodes
`ifdef CU_STACK_EN
        fetchI(5'd8, 1'b0, 0);
        step("pushDecode", B_BSY);
        step("pushExec", B_BSY | B_SPW | B_MW | B_MS);
        fetchI(5'd9, 1'b0, 0);
        step("popDecode", B_BSY);
        step("popExec", B_BSY | B_SPW | B_SPS);
        step("popMem", B_BSY | B_MR | B_MS);
        step("popWb", B_BSY | B_MYW | M_MEM);
`else
        fetchI(5'd8, 1'b0, 0);
        step("op8Decode", B_BSY | B_F);
        step("op8Halt", B_BSY | B_F);
        faultReset();
`endif

        // illegal opcode
        fetchI(5'd13, 1'b0, 0);
        step("illegalDecode", B_BSY | B_F);
        step("illegalHalt", B_BSY | B_F);
        faultReset();

        // STORE with memory stuck: fault after 15 MEM cycles, HALT is sticky
        fetchI(5'd4, 1'b0, 0);
        step("storeDecode", B_BSY);
        step("storeExec", B_BSY | A_PASS);
        MemReady = 1'b0;
        for (int i = 0; i < 15; i++) step("storeMemWait", B_BSY | B_MW | B_MS);
        step("timeoutHalt", B_BSY | B_F);
        MemReady = 1'b1;
        step("haltStays", B_BSY | B_F);
        step("haltStays", B_BSY | B_F);
        faultReset();

        fetchI(5'd0, 1'b0, 0);
        step("aputDecode", B_BSY);
        step("aputExec", B_BSY);
        step("postResetWb", B_BSY | B_MYW | M_IMM);

        chk("sbDrain", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
